gpio_fsel_ctrl: RTL and testbench

Sequencer that owns the per-pad function-select (fsel) state of the GPIO pad mux and applies changes safely.
- Accepts one "switch pad P to function F" request at a time.
- Tristates pad P (force OE low) for a programmable turnaround before and after the mux changes, so the old and new drivers never glitch or contend on the pad.
- Sits between the APB register block (requester) and the GPIO mux (fsel_o and oe_kill_o consumers).

---
 rtl/gpio_fsel_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_gpio_fsel_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_fsel_ctrl.sv
// gpio_fsel_ctrl
// Owns the per-pad function-select state of the GPIO pad mux and changes one
// pad at a time. The pad is forced tristate for a turnaround before and after
// the mux switches, so the old and new drivers never contend on the pad.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   req_valid/ready request handshake (ready only while idle)
//   req_pad         target pad index
//   req_fsel        requested function for that pad
//   req_turn        turnaround length in cycles (0 behaves as 1)
//   fsel_o          packed fsel, pad i at [i*W_FSEL +: W_FSEL]
//   oe_kill_o       per-pad force-tristate to the mux
//   busy            kill/switch/settle sequence in progress
//   done            one-cycle completion pulse
//   err             qualifies done: request rejected (pad out of range)
// All outputs are registered.
module gpio_fsel_ctrl #(
    parameter int N_PADS = 16,
    parameter int W_FSEL = 1,
    parameter int W_PAD  = 4,
    parameter int W_TURN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [W_PAD-1:0]           req_pad,
    input  logic [W_FSEL-1:0]          req_fsel,
    input  logic [W_TURN-1:0]          req_turn,
    output logic [N_PADS*W_FSEL-1:0]   fsel_o,
    output logic [N_PADS-1:0]          oe_kill_o,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KILL,
        S_SWITCH,
        S_SETTLE,
        S_DONE
    } state_t;

    // One extra bit so the pad count itself is representable for the range check.
    localparam int            N_PADS_I = N_PADS;
    localparam logic [W_PAD:0] N_PADS_W = N_PADS_I[W_PAD:0];

    state_t              state_q, state_d;
    logic [W_PAD-1:0]    pad_q, pad_d;
    logic [W_FSEL-1:0]   fsel_new_q, fsel_new_d;
    logic [W_TURN-1:0]   turn_q, turn_d;
    logic [W_TURN-1:0]   cnt_q, cnt_d;
    logic                ready_q, busy_q, done_q, err_q, err_d;
    logic [N_PADS-1:0]   kill_q, kill_d;
    logic                kill_on_d;
    logic                fsel_upd;
    logic                accept;
    logic [W_TURN-1:0]   req_t;
    logic                pad_in_range;
    logic [W_FSEL-1:0]   cur_fsel;

    assign accept       = req_valid && ready_q;
    // A zero turnaround still needs one tristate cycle on each side.
    assign req_t        = (req_turn == '0) ? W_TURN'(1) : req_turn;
    assign pad_in_range = ({1'b0, req_pad} < N_PADS_W);

    // Current function of the requested pad; out-of-range pads read as 0 and
    // are rejected anyway.
    always_comb begin
        cur_fsel = '0;
        for (int i = 0; i < N_PADS; i++) begin
            if (req_pad == W_PAD'(i)) begin
                cur_fsel = fsel_o[i*W_FSEL +: W_FSEL];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pad_d      = pad_q;
        fsel_new_d = fsel_new_q;
        turn_d     = turn_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        fsel_upd   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    pad_d      = req_pad;
                    fsel_new_d = req_fsel;
                    turn_d     = req_t;
                    if (!pad_in_range) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else if (cur_fsel == req_fsel) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_KILL;
                        cnt_d   = req_t;
                    end
                end
            end
            S_KILL: begin
                // Counter holds the cycles left in this phase including the current one.
                if (cnt_q == W_TURN'(1)) begin
                    state_d = S_SWITCH;
                end else begin
                    cnt_d = cnt_q - W_TURN'(1);
                end
            end
            S_SWITCH: begin
                fsel_upd = 1'b1;
                cnt_d    = turn_q;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == W_TURN'(1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - W_TURN'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    assign kill_on_d = (state_d == S_KILL) || (state_d == S_SWITCH) || (state_d == S_SETTLE);

    genvar gi;
    generate
        for (gi = 0; gi < N_PADS; gi++) begin : g_pad
            logic [W_FSEL-1:0] fsel_pad_q;

            assign kill_d[gi] = kill_on_d && (pad_d == W_PAD'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    fsel_pad_q <= '0;
                end else if (fsel_upd && (pad_q == W_PAD'(gi))) begin
                    fsel_pad_q <= fsel_new_q;
                end
            end

            assign fsel_o[gi*W_FSEL +: W_FSEL] = fsel_pad_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pad_q      <= '0;
            fsel_new_q <= '0;
            turn_q     <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            kill_q     <= '0;
        end else begin
            state_q    <= state_d;
            pad_q      <= pad_d;
            fsel_new_q <= fsel_new_d;
            turn_q     <= turn_d;
            cnt_q      <= cnt_d;
            ready_q    <= (state_d == S_IDLE);
            busy_q     <= kill_on_d;
            done_q     <= (state_d == S_DONE);
            err_q      <= err_d;
            kill_q     <= kill_d;
        end
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign oe_kill_o = kill_q;

endmodule

// File: tb/tb_gpio_fsel_ctrl.sv
// Bench for gpio_fsel_ctrl. Model is a timeline: cycles elapsed since the
// accepting edge determine every output.
module tb_gpio_fsel_ctrl;

    localparam int N_PADS = 16;
    localparam int W_FSEL = 1;
    localparam int W_PAD  = 5;
    localparam int W_TURN = 4;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      req_valid = 1'b0;
    logic                      req_ready;
    logic [W_PAD-1:0]          req_pad = '0;
    logic [W_FSEL-1:0]         req_fsel = '0;
    logic [W_TURN-1:0]         req_turn = '0;
    logic [N_PADS*W_FSEL-1:0]  fsel_o;
    logic [N_PADS-1:0]         oe_kill_o;
    logic                      busy, done, err;

    gpio_fsel_ctrl #(
        .N_PADS(N_PADS), .W_FSEL(W_FSEL), .W_PAD(W_PAD), .W_TURN(W_TURN)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_pad(req_pad), .req_fsel(req_fsel), .req_turn(req_turn),
        .fsel_o(fsel_o), .oe_kill_o(oe_kill_o),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int unsigned nvec = 0;
    int unsigned nerr = 0;
    int          cyc  = 0;
    bit          checking = 1'b0;

    // Model state
    logic [W_FSEL-1:0] m_fsel [N_PADS];
    bit                m_act;
    int                m_k, m_T, m_pad, m_kind, m_last; // kind: 0 switch, 1 no-op, 2 reject
    logic [W_FSEL-1:0] m_new;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_PADS; i++) m_fsel[i] = '0;
        m_act = 1'b0;
        m_k   = 0;
    endtask

    task automatic check_model();
        logic                     e_busy, e_done, e_err;
        logic [N_PADS-1:0]        e_kill;
        logic [N_PADS*W_FSEL-1:0] e_fsel;
        e_busy = m_act && (m_kind == 0) && (m_k <= 2*m_T + 1);
        e_done = m_act && (m_k == m_last);
        e_err  = e_done && (m_kind == 2);
        e_kill = e_busy ? (N_PADS'(1) << m_pad) : '0;
        for (int i = 0; i < N_PADS; i++) e_fsel[i*W_FSEL +: W_FSEL] = m_fsel[i];
        chk("req_ready", 64'(req_ready), 64'(!m_act));
        chk("busy",      64'(busy),      64'(e_busy));
        chk("done",      64'(done),      64'(e_done));
        chk("err",       64'(err),       64'(e_err));
        chk("oe_kill_o", 64'(oe_kill_o), 64'(e_kill));
        chk("fsel_o",    64'(fsel_o),    64'(e_fsel));
    endtask

    task automatic model_step(input bit r, input bit v, input int pad, input int fs, input int turn);
        bit was_act;
        if (r) begin
            model_reset();
            return;
        end
        was_act = m_act;
        if (m_act) begin
            m_k++;
            if (m_kind == 0 && m_k == m_T + 2) m_fsel[m_pad] = m_new;
            if (m_k > m_last) m_act = 1'b0;
        end
        if (!was_act && v) begin
            m_act = 1'b1;
            m_k   = 1;
            m_T   = (turn == 0) ? 1 : turn;
            m_pad = pad;
            m_new = W_FSEL'(fs);
            if (pad >= N_PADS)                    m_kind = 2;
            else if (m_fsel[pad] == W_FSEL'(fs))  m_kind = 1;
            else                                  m_kind = 0;
            m_last = (m_kind == 0) ? 2*m_T + 2 : 1;
            $display("cycle %0d accept pad=%0d fsel=%0d turn=%0d kind=%0d", cyc, pad, fs, turn, m_kind);
        end
    endtask

    // Called just after a falling edge: check current outputs, drive inputs,
    // advance model across the rising edge, return after the next falling edge.
    task automatic tick(input bit r, input bit v, input int pad, input int fs, input int turn);
        if (checking) check_model();
        rst       = r;
        req_valid = v;
        req_pad   = W_PAD'(pad);
        req_fsel  = W_FSEL'(fs);
        req_turn  = W_TURN'(turn);
        @(posedge clk);
        model_step(r, v, pad, fs, turn);
        if (r) checking = 1'b1;
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic drain();
        int n = 0;
        while (m_act && n < 40) begin
            idle();
            n++;
        end
        chk("drain_to_idle", 64'(req_ready), 64'(1));
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // Reset then idle
        repeat (3) tick(1'b1, 1'b0, 0, 0, 0);
        chk("post_rst_ready", 64'(req_ready), 64'(1));
        chk("post_rst_fsel",  64'(fsel_o),    64'(0));
        chk("post_rst_kill",  64'(oe_kill_o), 64'(0));
        chk("post_rst_busy",  64'(busy),      64'(0));

        // Normal switch: pad 5, fsel 1, turn 2
        tick(1'b0, 1'b1, 5, 1, 2);
        for (int c = 1; c <= 7; c++) begin
            chk("sw_kill5", 64'(oe_kill_o[5]), 64'(c >= 1 && c <= 5));
            chk("sw_fsel5", 64'(fsel_o[5]),    64'(c >= 4));
            chk("sw_done",  64'(done),         64'(c == 6));
            chk("sw_ready", 64'(req_ready),    64'(c == 7));
            idle();
        end
        chk("sw_fsel_final", 64'(fsel_o), 64'(16'h0020));

        // No-op: same pad and function again
        tick(1'b0, 1'b1, 5, 1, 3);
        chk("noop_done", 64'(done),      64'(1));
        chk("noop_err",  64'(err),       64'(0));
        chk("noop_kill", 64'(oe_kill_o), 64'(0));
        idle();
        chk("noop_ready", 64'(req_ready), 64'(1));

        // Zero turnaround behaves as one
        tick(1'b0, 1'b1, 3, 1, 0);
        for (int c = 1; c <= 5; c++) begin
            chk("t0_done",  64'(done),         64'(c == 4));
            chk("t0_kill3", 64'(oe_kill_o[3]), 64'(c >= 1 && c <= 3));
            idle();
        end

        // Reject: pad out of range
        tick(1'b0, 1'b1, 16, 1, 2);
        chk("rej_done", 64'(done),      64'(1));
        chk("rej_err",  64'(err),       64'(1));
        chk("rej_kill", 64'(oe_kill_o), 64'(0));
        chk("rej_fsel", 64'(fsel_o),    64'(16'h0028));
        idle();

        // Back-to-back: valid held, inputs change every cycle
        for (int i = 0; i < 60; i++)
            tick(1'b0, 1'b1, int'($urandom_range(0, 17)), int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        drain();

        // Reset mid-op: pad 7, max turnaround, reset while settling (cycle 20)
        tick(1'b0, 1'b1, 7, int'(~m_fsel[7]), 15);
        for (int c = 1; c < 20; c++) idle();
        chk("mid_busy", 64'(busy), 64'(1));
        tick(1'b1, 1'b0, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            chk("mid_fsel", 64'(fsel_o),    64'(0));
            chk("mid_kill", 64'(oe_kill_o), 64'(0));
            chk("mid_busy0", 64'(busy),     64'(0));
            chk("mid_done", 64'(done),      64'(0));
            idle();
        end

        // Randomized traffic with rare resets and full turnaround range
        for (int i = 0; i < 400; i++) begin
            bit r;
            r = ($urandom_range(0, 99) == 0);
            tick(r, bit'($urandom_range(0, 2) != 0), int'($urandom_range(0, 17)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
        end
        drain();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
